// File: rtl/rmst_resp_mem_pkg.sv
// Shared constants for the rmst_resp_mem responder: default widths, word geometry
// and the FSM state encoding, plus a debug view of the controller.
package rmst_resp_mem_pkg;

    localparam int XAW_DEFAULT    = 32;
    localparam int XDW_DEFAULT    = 128;
    localparam int MEM_AW_DEFAULT = 10;
    localparam int FD_AW_DEFAULT  = 2;

    // One user word is 16 bytes; byte addresses/lengths shift down by 4.
    localparam int BYTES_PER_WORD = 16;
    localparam int WORD_SHIFT     = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Snapshot of the controller for checkers bound to the top.
    typedef struct packed {
        logic [1:0] state;
        logic       issue;
        logic       inflight;
        logic       remaining_nz;
        logic       done;
    } resp_dbg_t;

endpackage

// File: rtl/rmst_resp_mem_fifo.sv
// Show-ahead FIFO: the head word is presented combinationally while non-empty.
// Pop on empty and push on full are ignored; count reports occupancy.
module resp_showahead_fifo #(
    parameter int XDW   = 128,
    parameter int FD_AW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [XDW-1:0]   push_data,
    input  logic             pop,
    output logic [XDW-1:0]   head_data,
    output logic             head_valid,
    output logic [FD_AW:0]   count
);

    localparam int DEPTH = 2 ** FD_AW;
    localparam logic [FD_AW:0] FULL_COUNT = (FD_AW + 1)'(DEPTH);

    logic [XDW-1:0]   mem [DEPTH];
    logic [FD_AW-1:0] wr_ptr;
    logic [FD_AW-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok     = pop && (count != '0);
    assign push_ok    = push && ((count != FULL_COUNT) || pop_ok);
    assign head_valid = (count != '0);
    // Head reads as zero when empty so the output is defined out of reset.
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + FD_AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + FD_AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (FD_AW + 1)'(1);
                2'b01:   count <= count - (FD_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rmst_resp_mem.sv
// Memory-side responder for the read-master control/user interface: a go request
// streams words from an internal RAM through a show-ahead buffer, then raises done.
module rmst_resp_mem
    import rmst_resp_mem_pkg::*;
#(
    parameter int XAW    = XAW_DEFAULT,
    parameter int XDW    = XDW_DEFAULT,
    parameter int MEM_AW = MEM_AW_DEFAULT,
    parameter int FD_AW  = FD_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              control_fixed_location,
    input  logic [XAW-1:0]    control_read_base,
    input  logic [XAW-1:0]    control_read_length,
    input  logic              control_go,
    output logic              control_done,
    input  logic              user_read_buffer,
    output logic [XDW-1:0]    user_buffer_output_data,
    output logic              user_data_available,
    input  logic              init_wr_en,
    input  logic [MEM_AW-1:0] init_wr_addr,
    input  logic [XDW-1:0]    init_wr_data
);

    localparam logic [FD_AW:0] FIFO_DEPTH = (FD_AW + 1)'(2 ** FD_AW);

    logic [1:0]        state_q;
    logic [MEM_AW-1:0] addr_q;
    logic [XAW-1:0]    remaining_q;
    logic              fixed_q;
    logic              inflight_q;
    logic              done_q;

    logic [XDW-1:0]    ram [2 ** MEM_AW];
    logic [XDW-1:0]    rd_data_q;

    logic [FD_AW:0]    fifo_count;
    logic              fifo_valid;
    logic [FD_AW:0]    occupancy;
    logic [XAW-1:0]    go_words;
    logic [MEM_AW-1:0] go_addr;
    logic              issue;
    logic              pop_fire;
    logic              buf_empty_next;

    resp_dbg_t         fsm_dbg;
    logic              unused_ok;

    assign go_words = control_read_length >> WORD_SHIFT;
    assign go_addr  = control_read_base[MEM_AW+WORD_SHIFT-1:WORD_SHIFT];

    // The in-flight read already owns a buffer slot, so the buffer cannot overflow.
    assign occupancy = fifo_count + {{FD_AW{1'b0}}, inflight_q};
    assign issue     = (state_q == ST_FETCH) && (remaining_q != '0) && (occupancy < FIFO_DEPTH);

    assign pop_fire       = user_read_buffer && fifo_valid;
    assign buf_empty_next = (fifo_count == '0) ||
                            ((fifo_count == (FD_AW + 1)'(1)) && pop_fire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            fixed_q     <= 1'b0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b1;
        end else begin
            inflight_q <= issue;
            case (state_q)
                ST_IDLE: begin
                    // A zero-word request leaves the responder idle with done held.
                    if (control_go && (go_words != '0)) begin
                        addr_q      <= go_addr;
                        remaining_q <= go_words;
                        fixed_q     <= control_fixed_location;
                        done_q      <= 1'b0;
                        state_q     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (issue) begin
                        remaining_q <= remaining_q - XAW'(1);
                        if (!fixed_q) begin
                            addr_q <= addr_q + MEM_AW'(1);
                        end
                        if (remaining_q == XAW'(1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Done rises in the same cycle the buffer becomes empty.
                    if (!inflight_q && buf_empty_next) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (init_wr_en) begin
            ram[init_wr_addr] <= init_wr_data;
        end
    end

    // Read-before-write: a same-cycle write to the read address returns old data.
    always_ff @(posedge clk) begin
        if (issue) begin
            rd_data_q <= ram[addr_q];
        end
    end

    resp_showahead_fifo #(
        .XDW   (XDW),
        .FD_AW (FD_AW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_data  (rd_data_q),
        .pop        (user_read_buffer),
        .head_data  (user_buffer_output_data),
        .head_valid (fifo_valid),
        .count      (fifo_count)
    );

    assign user_data_available = fifo_valid;
    assign control_done        = done_q;

    assign fsm_dbg = '{
        state:        state_q,
        issue:        issue,
        inflight:     inflight_q,
        remaining_nz: (remaining_q != '0),
        done:         done_q
    };

    assign unused_ok = ^{fsm_dbg,
                         control_read_base[XAW-1:MEM_AW+WORD_SHIFT],
                         control_read_base[WORD_SHIFT-1:0],
                         control_read_length[WORD_SHIFT-1:0]};

endmodule

// File: tb/tb_rmst_resp_mem.sv
// Bench for rmst_resp_mem: directed and random transfers against a byte-address
// reference model, with a scoreboard monitor checking every consumed word.
module tb_rmst_resp_mem;

    localparam int XAW       = 32;
    localparam int XDW       = 128;
    localparam int MEM_AW    = 10;
    localparam int FD_AW     = 2;
    localparam int MEM_WORDS = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              control_fixed_location;
    logic [XAW-1:0]    control_read_base;
    logic [XAW-1:0]    control_read_length;
    logic              control_go;
    logic              control_done;
    logic              user_read_buffer;
    logic [XDW-1:0]    user_buffer_output_data;
    logic              user_data_available;
    logic              init_wr_en;
    logic [MEM_AW-1:0] init_wr_addr;
    logic [XDW-1:0]    init_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XDW-1:0] exp_q[$];
    logic [XDW-1:0] model_mem [MEM_WORDS];

    int cons_mode   = 0;
    int manual_pops = 0;
    int pops_seen   = 0;
    bit done_pending = 1'b0;

    rmst_resp_mem #(
        .XAW    (XAW),
        .XDW    (XDW),
        .MEM_AW (MEM_AW),
        .FD_AW  (FD_AW)
    ) u_dut (
        .clk                     (clk),
        .rst                     (rst),
        .control_fixed_location  (control_fixed_location),
        .control_read_base       (control_read_base),
        .control_read_length     (control_read_length),
        .control_go              (control_go),
        .control_done            (control_done),
        .user_read_buffer        (user_read_buffer),
        .user_buffer_output_data (user_buffer_output_data),
        .user_data_available     (user_data_available),
        .init_wr_en              (init_wr_en),
        .init_wr_addr            (init_wr_addr),
        .init_wr_data            (init_wr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [XDW-1:0] got, input logic [XDW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Consumer: 0 always, 1 every third cycle, 2 random, 3 manual count.
    initial begin
        int cyc;
        cyc = 0;
        user_read_buffer = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (cons_mode)
                0: user_read_buffer = 1'b1;
                1: user_read_buffer = ((cyc % 3) == 0);
                2: user_read_buffer = ($urandom_range(0, 3) != 0);
                default: begin
                    if (manual_pops > 0 && user_data_available) begin
                        user_read_buffer = 1'b1;
                        manual_pops--;
                    end else begin
                        user_read_buffer = 1'b0;
                    end
                end
            endcase
        end
    end

    // Monitor: every accepted head word is popped from the expected queue.
    initial begin
        logic [XDW-1:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_pending = 1'b0;
            end else begin
                if (done_pending) begin
                    check_val("done_after_last_pop", int'(control_done), 1);
                    check_val("avail_after_last_pop", int'(user_data_available), 0);
                    done_pending = 1'b0;
                end
                if (user_data_available && user_read_buffer) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %h, required no word", user_buffer_output_data);
                    end else begin
                        exp = exp_q.pop_front();
                        check_word("word", user_buffer_output_data, exp);
                        pops_seen++;
                        if (exp_q.size() == 0) begin
                            done_pending = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Reference: words come from byte_base/16 modulo RAM size, length/16 of them.
    task automatic do_go(input logic [XAW-1:0] base, input logic [XAW-1:0] len,
                         input logic fixed, input bit expect_accept);
        int words;
        int start;
        int lat;
        words = int'(len / 16);
        start = int'((base / 16) % MEM_WORDS);
        if (expect_accept) begin
            for (int i = 0; i < words; i++) begin
                exp_q.push_back(model_mem[fixed ? start : (start + i) % MEM_WORDS]);
            end
        end
        @(posedge clk);
        #1;
        control_read_base      = base;
        control_read_length    = len;
        control_fixed_location = fixed;
        control_go             = 1'b1;
        @(posedge clk);
        #1;
        control_go = 1'b0;
        if (expect_accept) begin
            check_val("done_after_go", int'(control_done), (words == 0) ? 1 : 0);
            if (words > 0) begin
                lat = 1;
                while (!user_data_available && lat < 10) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                check_val("first_data_latency", lat, 3);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && control_done === 1'b1) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val(name, int'(n < 3000), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [XDW-1:0] d;
        logic [31:0]    a32;
        bit             seen_avail;
        int             start_pops;
        int             n;

        rst                    = 1'b1;
        control_fixed_location = 1'b0;
        control_read_base      = '0;
        control_read_length    = '0;
        control_go             = 1'b0;
        init_wr_en             = 1'b0;
        init_wr_addr           = '0;
        init_wr_data           = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_done", int'(control_done), 1);
        check_val("reset_avail", int'(user_data_available), 0);
        check_word("reset_data", user_buffer_output_data, '0);
        rst = 1'b0;

        for (int a = 0; a < MEM_WORDS; a++) begin
            @(posedge clk);
            #1;
            a32 = a;
            d = (a < 16) ? {4{a32}} : {$urandom, $urandom, $urandom, $urandom};
            init_wr_en   = 1'b1;
            init_wr_addr = a32[MEM_AW-1:0];
            init_wr_data = d;
            model_mem[a] = d;
        end
        @(posedge clk);
        #1;
        init_wr_en = 1'b0;

        // Pops while empty must not disturb the buffer.
        cons_mode = 2;
        seen_avail = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (user_data_available || user_buffer_output_data != '0) seen_avail = 1'b1;
        end
        check_val("empty_pop_ignored", int'(seen_avail), 0);

        cons_mode = 0;
        do_go(32'h40, 32'h80, 1'b0, 1'b1);
        wait_idle("basic_done");

        cons_mode = 1;
        do_go(32'h40, 32'h80, 1'b0, 1'b1);
        wait_idle("slow_consumer_done");

        cons_mode = 2;
        do_go(32'h50, 32'h40, 1'b1, 1'b1);
        wait_idle("fixed_done");

        do_go((MEM_WORDS - 2) * 16, 32'h40, 1'b0, 1'b1);
        wait_idle("wrap_done");

        do_go(32'h0, 32'h0, 1'b0, 1'b1);
        seen_avail = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (user_data_available || !control_done) seen_avail = 1'b1;
        end
        check_val("zero_length_idle", int'(seen_avail), 0);

        cons_mode = 0;
        do_go(32'h30, 32'h1F, 1'b0, 1'b1);
        wait_idle("one_word_done");

        cons_mode = 1;
        do_go(32'h40, 32'h80, 1'b0, 1'b1);
        do_go(32'h100, 32'h40, 1'b0, 1'b0);
        wait_idle("ignored_go_done");

        // Reset mid-transfer after three words are consumed.
        cons_mode   = 3;
        manual_pops = 3;
        start_pops  = pops_seen;
        do_go(32'h40, 32'h80, 1'b0, 1'b1);
        n = 0;
        while (pops_seen < start_pops + 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("three_pops_seen", pops_seen - start_pops, 3);
        check_val("done_low_mid_transfer", int'(control_done), 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("rst_done_immediate", int'(control_done), 1);
        check_val("rst_avail_immediate", int'(user_data_available), 0);
        exp_q.delete();
        manual_pops = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cons_mode = 0;
        do_go(32'h0, 32'h20, 1'b0, 1'b1);
        wait_idle("after_reset_done");

        for (int t = 0; t < 12; t++) begin
            cons_mode = $urandom_range(0, 2);
            do_go($urandom, $urandom_range(0, 32'h300), ($urandom_range(0, 7) == 0), 1'b1);
            wait_idle("random_done");
        end

        check_val("queue_empty_at_end", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rmst_resp_mem.md
Name: rmst_resp_mem

Overview:
- Synthesizable memory-side responder for the Avalon read-master control/user interface that rmst_to_fifo_tile drives.
- Accepts a go/base/length transfer request and streams XDW-bit words from an internal RAM through a show-ahead output buffer using data_available/read_buffer.
- Raises done when the transfer is complete.
- Replaces the behavioural memory model's read path in tile-level benches and in on-chip loopback builds.

Parameters:
- XAW, 32, control address/length width (byte units)
- XDW, 128, user data width
- MEM_AW, 10, word address width of internal RAM (2^MEM_AW words of XDW bits)
- FD_AW, 2, output buffer depth log2 (depth 4)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- control_fixed_location  in  1  1 = re-read the same word for the whole transfer
- control_read_base  in  XAW  byte start address, sampled on go
- control_read_length  in  XAW  byte count, sampled on go
- control_go  in  1  single-cycle start pulse
- control_done  out  1  high when idle and all words consumed
- user_read_buffer  in  1  consumer acknowledges the current head word
- user_buffer_output_data  out  XDW  head word (show-ahead)
- user_data_available  out  1  output buffer non-empty
- init_wr_en  in  1  preload write strobe
- init_wr_addr  in  MEM_AW  preload word address
- init_wr_data  in  XDW  preload data

Behaviour:
- One clock domain: clk. Reset: asynchronous, active-high (rst).
- Reset values: control_done=1, user_data_available=0, user_buffer_output_data=0; state IDLE; word counter, in-flight flag and buffer count cleared. RAM contents are not reset.
- Address math:
  - word address = read_base[MEM_AW+3:4]; byte offset bits [3:0] ignored.
  - word count = read_length >> 4; remainder bytes dropped.
  - Address increments by 1 per issued word, modulo 2^MEM_AW (wraps); held constant when fixed_location=1.
- RAM: simple dual-port, synchronous read with 1-cycle latency.
  - Preload port write has priority-free independent access.
  - Same-cycle read and write to one address returns old data.
- FSM:
  - IDLE: on go, latch addr/count/fixed, deassert done next cycle. If count=0, stay IDLE with done=1 (no words produced).
  - FETCH: issue one RAM read per cycle while (buffer_count + inflight) < 2^FD_AW and remaining>0. The word is pushed into the buffer the cycle after issue. When remaining reaches 0 -> DRAIN.
  - DRAIN: wait for inflight=0 and buffer empty, then IDLE with done=1 in the same cycle the buffer empties.
- Latency: go at cycle 0 -> first read issued cycle 1 -> data_available=1 at cycle 3. Sustained throughput is 1 word/cycle when the consumer reads every cycle.
- Handshake:
  - read_buffer pops the head only when data_available=1; read_buffer while empty is ignored (no underflow, count unchanged).
  - Push and pop in the same cycle: count unchanged, order preserved.
  - The buffer never overflows: the issue condition counts the in-flight read.
- go while not IDLE: ignored; current transfer continues unchanged.
- rst mid-transfer: buffer flushed, in-flight data discarded, done=1 immediately (asynchronous).
- control_done is a level, not a pulse, matching the read-master template.

Decomposition:
- Shared package: XDW/XAW defaults, bytes-per-word constant (16) and its shift (4), FSM state encoding (IDLE/FETCH/DRAIN).
- One natural sub-module: resp_showahead_fifo, a parameterized (XDW, FD_AW) show-ahead FIFO with count output. The top holds the FSM, address/count registers and the RAM.

Test Plan:
- Preload words 0..15 with value {4{addr}}; go base=0x40 length=0x80, consumer always reading -> 8 words 4..11 in order, data_available first at cycle 3 after go, done re-asserts the cycle after the 8th pop.
- Same transfer, consumer reads only every 3rd cycle -> buffer count never exceeds 4, no word lost or duplicated, 8 words total.
- fixed_location=1, base=0x50, length=0x40 -> 4 words all equal to word 5.
- Wrap: base=(2^MEM_AW-2)*16, length=0x40 -> words 1022,1023,0,1 in order. Also length=0x0 -> done stays 1, data_available never rises. Also length=0x1F -> exactly 1 word.
- Robustness:
  - Second go issued during FETCH -> ignored; only the first transfer's words appear.
  - read_buffer pulses while empty -> no change in count or data.
- rst asserted after 3 of 8 words are consumed -> done=1 and data_available=0 immediately. A new go base=0 length=0x20 after reset -> words 0,1 only.
